// File: rtl/sha_miner_pkg.sv
// Shared types and helpers for the SHA-256 nonce search sequencer.
package sha_miner_pkg;

    localparam int MSG_W   = 512;
    localparam int DIG_W   = 256;
    localparam int NONCE_W = 32;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_CHECK = 3'd3,
        ST_FIN   = 3'd4
    } state_e;

    function automatic logic [MSG_W-1:0] insert_nonce(
        input logic [MSG_W-1:0]   tmpl,
        input logic [NONCE_W-1:0] nonce,
        input int unsigned        word
    );
        logic [MSG_W-1:0] blk;
        blk = tmpl;
        blk[NONCE_W*word +: NONCE_W] = nonce;
        return blk;
    endfunction

endpackage

// File: rtl/sha256_nonce_search.sv
// Sweeps an inclusive nonce range through one external sha256 core and compares
// each digest against a target, stopping on hit, exhaustion, abort or core timeout.
module sha256_nonce_search
    import sha_miner_pkg::*;
#(
    parameter int unsigned NONCE_WORD   = 12,
    parameter int unsigned CORE_TIMEOUT = 128
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic [MSG_W-1:0]   cfg_template,
    input  logic [NONCE_W-1:0] cfg_nonce_start,
    input  logic [NONCE_W-1:0] cfg_nonce_end,
    input  logic [DIG_W-1:0]   cfg_target,
    output logic               core_start,
    output logic [MSG_W-1:0]   core_data_in,
    input  logic               core_done,
    input  logic [DIG_W-1:0]   core_data_out,
    output logic               busy,
    output logic               done,
    output logic               found,
    output logic               exhausted,
    output logic               timeout_err,
    output logic [NONCE_W-1:0] result_nonce,
    output logic [DIG_W-1:0]   result_digest,
    output logic [31:0]        attempts
);

    localparam int WD_W = (CORE_TIMEOUT > 2) ? $clog2(CORE_TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(CORE_TIMEOUT - 1);

    state_e             state_q, state_d;
    logic [MSG_W-1:0]   template_q, template_d;
    logic [DIG_W-1:0]   target_q, target_d;
    logic [NONCE_W-1:0] end_q, end_d;
    logic [NONCE_W-1:0] nonce_q, nonce_d;
    logic [DIG_W-1:0]   digest_q, digest_d;
    logic [WD_W-1:0]    wdog_q, wdog_d;
    logic               core_start_q, core_start_d;
    logic [MSG_W-1:0]   core_data_in_q, core_data_in_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               found_q, found_d;
    logic               exhausted_q, exhausted_d;
    logic               timeout_err_q, timeout_err_d;
    logic [NONCE_W-1:0] result_nonce_q, result_nonce_d;
    logic [DIG_W-1:0]   result_digest_q, result_digest_d;
    logic [31:0]        attempts_q, attempts_d;

    // Next-state logic; abort outside IDLE overrides every other transition
    always_comb begin
        state_d         = state_q;
        template_d      = template_q;
        target_d        = target_q;
        end_d           = end_q;
        nonce_d         = nonce_q;
        digest_d        = digest_q;
        wdog_d          = wdog_q;
        core_start_d    = 1'b0;
        core_data_in_d  = core_data_in_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        found_d         = found_q;
        exhausted_d     = exhausted_q;
        timeout_err_d   = timeout_err_q;
        result_nonce_d  = result_nonce_q;
        result_digest_d = result_digest_q;
        attempts_d      = attempts_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        template_d     = cfg_template;
                        target_d       = cfg_target;
                        end_d          = cfg_nonce_end;
                        nonce_d        = cfg_nonce_start;
                        core_data_in_d = insert_nonce(cfg_template, cfg_nonce_start, NONCE_WORD);
                        core_start_d   = 1'b1;
                        busy_d         = 1'b1;
                        found_d        = 1'b0;
                        exhausted_d    = 1'b0;
                        timeout_err_d  = 1'b0;
                        attempts_d     = 32'd0;
                        state_d        = ST_ISSUE;
                    end else begin
                        busy_d = 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wdog_d  = '0;
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (core_done) begin
                        digest_d = core_data_out;
                        state_d  = ST_CHECK;
                    end else if (wdog_q == WD_LAST) begin
                        timeout_err_d  = 1'b1;
                        result_nonce_d = nonce_q;
                        done_d         = 1'b1;
                        state_d        = ST_FIN;
                    end else begin
                        wdog_d = wdog_q + WD_W'(1);
                    end
                end
                ST_CHECK: begin
                    if (attempts_q != 32'hFFFF_FFFF) begin
                        attempts_d = attempts_q + 32'd1;
                    end else begin
                        attempts_d = attempts_q;
                    end
                    // A hit on the final nonce reports found, not exhausted
                    if (digest_q < target_q) begin
                        found_d         = 1'b1;
                        result_nonce_d  = nonce_q;
                        result_digest_d = digest_q;
                        done_d          = 1'b1;
                        state_d         = ST_FIN;
                    end else if (nonce_q == end_q) begin
                        exhausted_d = 1'b1;
                        done_d      = 1'b1;
                        state_d     = ST_FIN;
                    end else begin
                        nonce_d        = nonce_q + 32'd1;
                        core_data_in_d = insert_nonce(template_q, nonce_q + 32'd1, NONCE_WORD);
                        core_start_d   = 1'b1;
                        state_d        = ST_ISSUE;
                    end
                end
                ST_FIN: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
                default: begin
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // State and output registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            template_q      <= '0;
            target_q        <= '0;
            end_q           <= '0;
            nonce_q         <= '0;
            digest_q        <= '0;
            wdog_q          <= '0;
            core_start_q    <= 1'b0;
            core_data_in_q  <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            found_q         <= 1'b0;
            exhausted_q     <= 1'b0;
            timeout_err_q   <= 1'b0;
            result_nonce_q  <= '0;
            result_digest_q <= '0;
            attempts_q      <= 32'd0;
        end else begin
            state_q         <= state_d;
            template_q      <= template_d;
            target_q        <= target_d;
            end_q           <= end_d;
            nonce_q         <= nonce_d;
            digest_q        <= digest_d;
            wdog_q          <= wdog_d;
            core_start_q    <= core_start_d;
            core_data_in_q  <= core_data_in_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            found_q         <= found_d;
            exhausted_q     <= exhausted_d;
            timeout_err_q   <= timeout_err_d;
            result_nonce_q  <= result_nonce_d;
            result_digest_q <= result_digest_d;
            attempts_q      <= attempts_d;
        end
    end

    assign core_start    = core_start_q;
    assign core_data_in  = core_data_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign exhausted     = exhausted_q;
    assign timeout_err   = timeout_err_q;
    assign result_nonce  = result_nonce_q;
    assign result_digest = result_digest_q;
    assign attempts      = attempts_q;

endmodule

// File: tb/tb_sha256_nonce_search.sv
// Bench for sha256_nonce_search: behavioural sha256 core stand-in plus a sweep
// reference model derived from the range/compare rules.
module tb_sha256_nonce_search;

    localparam int NW = 12;
    localparam int TMO = 16;
    localparam logic [2047:0] K_TAB = {
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
    localparam logic [255:0] H_IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                     32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic start, abort, core_done;
    logic [511:0] cfg_template;
    logic [31:0] cfg_nonce_start, cfg_nonce_end;
    logic [255:0] cfg_target, core_data_out;
    logic core_start, busy, done, found, exhausted, timeout_err;
    logic [511:0] core_data_in;
    logic [31:0] result_nonce, attempts;
    logic [255:0] result_digest;

    int checks = 0;
    int failures = 0;
    int mode = 0;
    int lat = 1;
    int done_cnt = 0;
    logic [31:0] issued[$];
    logic [31:0] exp_q[$];
    logic found_e, exh_e;
    logic [31:0] rn_e, att_e;
    logic [255:0] rd_e;

    sha256_nonce_search #(.NONCE_WORD(NW), .CORE_TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .cfg_template(cfg_template), .cfg_nonce_start(cfg_nonce_start),
        .cfg_nonce_end(cfg_nonce_end), .cfg_target(cfg_target),
        .core_start(core_start), .core_data_in(core_data_in),
        .core_done(core_done), .core_data_out(core_data_out),
        .busy(busy), .done(done), .found(found), .exhausted(exhausted),
        .timeout_err(timeout_err), .result_nonce(result_nonce),
        .result_digest(result_digest), .attempts(attempts));

    always #5 clk = ~clk;

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha256_blk(input logic [511:0] blk);
        logic [2047:0] kt;
        logic [31:0] w[64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2, s0, s1;
        kt = K_TAB;
        for (int t = 0; t < 16; t++) w[t] = blk[511-32*t -: 32];
        for (int t = 16; t < 64; t++) begin
            s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = w[t-16] + s0 + w[t-7] + s1;
        end
        {a, b, c, d, e, f, g, h} = H_IV;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + kt[2047-32*t -: 32] + w[t];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {H_IV[255:224] + a, H_IV[223:192] + b, H_IV[191:160] + c, H_IV[159:128] + d,
                H_IV[127:96] + e, H_IV[95:64] + f, H_IV[63:32] + g, H_IV[31:0] + h};
    endfunction

    function automatic logic [511:0] ins(input logic [511:0] tm, input logic [31:0] n);
        logic [511:0] blk;
        blk = tm;
        blk[32*NW +: 32] = n;
        return blk;
    endfunction

    // Digest the stand-in core reports for a block, by mode
    function automatic logic [255:0] model_digest(input int m, input logic [511:0] blk);
        case (m)
            0: return sha256_blk(blk);
            1: return {224'd0, blk[32*NW +: 32]};
            4: return {224'd0, ~blk[32*NW +: 32]};
            default: return {256{1'b1}};
        endcase
    endfunction

    // Stand-in core: answers lat cycles after core_start; mode 2 never answers
    logic pend;
    int cnt;
    logic [511:0] blk_s;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            pend <= 1'b0; cnt <= 0; core_done <= 1'b0; core_data_out <= '0; blk_s <= '0;
        end else begin
            core_done <= 1'b0;
            if (core_start && mode != 2) begin
                pend <= 1'b1; cnt <= lat; blk_s <= core_data_in;
            end else if (pend) begin
                if (cnt <= 1) begin
                    pend <= 1'b0; core_done <= 1'b1; core_data_out <= model_digest(mode, blk_s);
                end else begin
                    cnt <= cnt - 1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (core_start === 1'b1) issued.push_back(core_data_in[32*NW +: 32]);
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_model(input logic [511:0] tm, input logic [31:0] s, input logic [31:0] e,
                             input logic [255:0] tg);
        logic [31:0] n;
        logic [255:0] d;
        exp_q.delete();
        found_e = 1'b0; exh_e = 1'b0; att_e = 32'd0; n = s;
        for (int k = 0; k < 1000; k++) begin
            exp_q.push_back(n);
            d = model_digest(mode, ins(tm, n));
            att_e = att_e + 32'd1;
            if (d < tg) begin found_e = 1'b1; rn_e = n; rd_e = d; break; end
            if (n == e) begin exh_e = 1'b1; break; end
            n = n + 32'd1;
        end
    endtask

    task automatic pulse_start(input logic [511:0] tm, input logic [31:0] s, input logic [31:0] e,
                               input logic [255:0] tg);
        @(negedge clk);
        cfg_template = tm; cfg_nonce_start = s; cfg_nonce_end = e; cfg_target = tg; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic sweep(input logic [511:0] tm, input logic [31:0] s, input logic [31:0] e,
                         input logic [255:0] tg, input string tag, input int glitch);
        int d0;
        ref_model(tm, s, e, tg);
        issued.delete();
        d0 = done_cnt;
        pulse_start(tm, s, e, tg);
        chk({tag, "_busy_rise"}, busy, 1);
        chk({tag, "_core_start"}, core_start, 1);
        for (int i = 0; i < 4000 && done !== 1'b1; i++) begin
            if (i == glitch) begin
                start = 1'b1; cfg_template = ~tm; cfg_nonce_start = ~s; cfg_nonce_end = ~s; cfg_target = '1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, done, 1);
        chk({tag, "_found"}, found, found_e);
        chk({tag, "_exhausted"}, exhausted, exh_e);
        chk({tag, "_timeout"}, timeout_err, 0);
        chk({tag, "_attempts"}, attempts, att_e);
        if (found_e) begin
            chk({tag, "_rnonce"}, result_nonce, rn_e);
            chk({tag, "_rdigest"}, result_digest, rd_e);
        end
        chk({tag, "_last_block"}, core_data_in, ins(tm, exp_q[$]));
        @(negedge clk);
        chk({tag, "_busy_fall"}, busy, 0);
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_done_pulses"}, done_cnt - d0, 1);
        chk({tag, "_n_issued"}, issued.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < issued.size(); i++)
            chk({tag, "_issued_nonce"}, issued[i], exp_q[i]);
    endtask

    initial begin
        logic [511:0] tm_ab, tm;
        logic [31:0] n12, s, e, s_to;
        logic [255:0] tg;
        int cyc, d0;

        start = 1'b0; abort = 1'b0;
        cfg_template = '0; cfg_nonce_start = '0; cfg_nonce_end = '0; cfg_target = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_flags", {found, exhausted, timeout_err, core_start}, 0);
        chk("rst_results", {result_nonce, attempts, result_digest}, 0);
        chk("rst_core_data", core_data_in, 0);

        // "abab..." message of 51 bytes, padded, length 0x198
        tm_ab = '0;
        for (int i = 0; i < 51; i++) tm_ab[511-8*i -: 8] = (i % 2 == 0) ? 8'h61 : 8'h62;
        tm_ab[511-8*51 -: 8] = 8'h80;
        tm_ab[63:0] = 64'h198;
        n12 = tm_ab[32*NW +: 32];

        mode = 0; lat = 3;
        sweep(tm_ab, n12, n12, '1, "hit1", -1);
        chk("hit1_block_unchanged", core_data_in, tm_ab);
        chk("hit1_attempts_const", attempts, 1);

        mode = 0; lat = 2;
        sweep(tm_ab, 32'd5, 32'd9, '0, "exhaust", -1);
        chk("exhaust_attempts_const", attempts, 5);

        mode = 1; lat = 1;
        sweep(tm_ab, 32'hFFFF_FFFE, 32'h0000_0001, 256'd1, "wrap", -1);
        chk("wrap_rnonce_const", result_nonce, 0);
        chk("wrap_attempts_const", attempts, 3);

        mode = 4; lat = 2;
        sweep(tm_ab, 32'd10, 32'd12, {224'd0, ~32'd12} + 256'd1, "lasthit", -1);

        mode = 5; lat = 1;
        sweep(tm_ab, 32'd1, 32'd2, '1, "allones", -1);

        for (int it = 0; it < 4; it++) begin
            mode = ($urandom_range(0, 1) == 0) ? 1 : 0;
            lat = $urandom_range(1, 5);
            for (int k = 0; k < 16; k++) tm[32*k +: 32] = $urandom;
            s = (it % 2 == 0) ? (32'hFFFF_FFFF - 32'($urandom_range(0, 3))) : $urandom;
            e = s + 32'($urandom_range(0, 6));
            tg = (mode == 1) ? {224'd0, s + 32'($urandom_range(0, 8))} : {$urandom, 224'd0};
            sweep(tm, s, e, tg, "rnd", -1);
        end

        mode = 1; lat = 2;
        sweep(tm_ab, 32'd20, 32'd24, '0, "busy_start", 3);

        // Core never answers: fault after TMO WAIT cycles
        mode = 2;
        s_to = $urandom;
        d0 = done_cnt;
        pulse_start(tm_ab, s_to, s_to, '1);
        chk("tmo_core_start", core_start, 1);
        cyc = 0;
        for (int i = 0; i < 200 && done !== 1'b1; i++) begin
            @(negedge clk);
            cyc++;
        end
        chk("tmo_wait_cycles", cyc - 1, TMO);
        chk("tmo_flag", timeout_err, 1);
        chk("tmo_rnonce", result_nonce, s_to);
        chk("tmo_found_exh", {found, exhausted}, 0);
        chk("tmo_attempts", attempts, 0);
        @(negedge clk);
        chk("tmo_done_pulses", done_cnt - d0, 1);

        // Abort on the same edge as core_done
        mode = 0; lat = 3;
        issued.delete();
        d0 = done_cnt;
        pulse_start(tm_ab, 32'd100, 32'd200, '0);
        for (int i = 0; i < 50 && core_done !== 1'b1; i++) @(negedge clk);
        chk("abort_core_done_seen", core_done, 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_core_start", core_start, 0);
        repeat (6) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);
        chk("abort_n_issued", issued.size(), 1);
        chk("abort_flags", {found, exhausted, timeout_err}, 0);
        chk("abort_rnonce_kept", result_nonce, s_to);
        chk("abort_attempts", attempts, 0);

        // Asynchronous reset while in CHECK
        mode = 1; lat = 1;
        pulse_start(tm_ab, 32'd50, 32'd60, '0);
        for (int i = 0; i < 50 && core_done !== 1'b1; i++) @(negedge clk);
        chk("arst_core_done_seen", core_done, 1);
        @(negedge clk);
        chk("arst_pre_busy", busy, 1);
        #1 reset = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_flags", {done, found, exhausted, timeout_err, core_start}, 0);
        chk("arst_results", {result_nonce, attempts, result_digest}, 0);
        chk("arst_core_data", core_data_in, 0);
        @(negedge clk);
        reset = 1'b0;
        mode = 0; lat = 3;
        sweep(tm_ab, n12, n12, '1, "post_rst", -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
